// File: rtl/irq_arbiter.sv
// Programmable interrupt arbiter: edge/level pending latch, mask, fixed-priority pick, one-hot HWInt with EOI handshake.
// Optional build macro IRQ_SYNC_EN adds a two-flop synchroniser on irq_in (+2 cycles irq-to-hwint latency).
module irq_arbiter #(
  parameter int          N_SRC     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [31:0]      dev_addr,
  input  logic             dev_we,
  input  logic [3:0]       dev_be,
  input  logic [31:0]      dev_wd,
  output logic [31:0]      dev_rd,
  input  logic             int_ack,
  output logic [5:0]       hwint
);

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

  localparam int PAD = 8 - N_SRC;

  state_t           state_q, state_d;
  logic [2:0]       cur_id_q, cur_id_d;
  logic [5:0]       hwint_q, hwint_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] irq_q, irq_d;
  logic [N_SRC-1:0] irq_s;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end
  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // Wrapping subtraction: any address outside the window lands on an unused offset.
  logic [31:0] off;
  logic        sel_mask, sel_mode, sel_pend, sel_stat, sel_eoi;
  logic        wr_ok, eoi_wr;
  assign off      = dev_addr - BASE_ADDR;
  assign sel_mask = (off == 32'h00);
  assign sel_mode = (off == 32'h04);
  assign sel_pend = (off == 32'h08);
  assign sel_stat = (off == 32'h0C);
  assign sel_eoi  = (off == 32'h10);
  assign wr_ok    = dev_we && (dev_be == 4'b1111);
  assign eoi_wr   = wr_ok && sel_eoi;

  logic unused_wd;
  assign unused_wd = &{1'b0, dev_wd[31:N_SRC]};

  logic [N_SRC-1:0] rise, w1c, eoi_clr, elig;
  logic [7:0]       cur_oh, next_oh, pend_ext, mask_ext;
  logic [2:0]       win;
  logic             cur_live;

  always_comb begin
    rise     = irq_s & ~irq_q;
    w1c      = (wr_ok && sel_pend) ? dev_wd[N_SRC-1:0] : '0;
    cur_oh   = 8'd1 << cur_id_q;
    eoi_clr  = (state_q == ST_SERVICE && eoi_wr) ? cur_oh[N_SRC-1:0] : '0;
    // Level bits track the line; edge bits: set beats any clear in the same cycle.
    pend_d   = (mode_q & irq_s) | (~mode_q & (rise | (pend_q & ~w1c & ~eoi_clr)));
    irq_d    = irq_s;
    mask_d   = (wr_ok && sel_mask) ? dev_wd[N_SRC-1:0] : mask_q;
    mode_d   = (wr_ok && sel_mode) ? dev_wd[N_SRC-1:0] : mode_q;
    elig     = pend_q & mask_q;
    pend_ext = {{PAD{1'b0}}, pend_q};
    mask_ext = {{PAD{1'b0}}, mask_q};
    cur_live = pend_ext[cur_id_q] & mask_ext[cur_id_q];
    win      = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win = 3'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d  = ST_ASSERT;
          cur_id_d = win;
        end
      end
      ST_ASSERT: begin
        // An ack already taken by the CPU wins over a same-cycle software cancel.
        if (int_ack)       state_d = ST_SERVICE;
        else if (!cur_live) state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (eoi_wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    next_oh = 8'd1 << cur_id_d;
    hwint_d = (state_d == ST_ASSERT) ? next_oh[5:0] : 6'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_id_q <= 3'd0;
      hwint_q  <= 6'd0;
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      irq_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      hwint_q  <= hwint_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

  assign hwint = hwint_q;

  always_comb begin
    dev_rd = 32'd0;
    if (sel_mask)      dev_rd = {{(32-N_SRC){1'b0}}, mask_q};
    else if (sel_mode) dev_rd = {{(32-N_SRC){1'b0}}, mode_q};
    else if (sel_pend) dev_rd = {{(32-N_SRC){1'b0}}, pend_q};
    else if (sel_stat) dev_rd = {22'd0, state_q == ST_SERVICE, state_q == ST_ASSERT, 5'd0, cur_id_q};
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Programmable interrupt controller between peripheral IRQ lines and the CPU's 6-bit HWInt input.
- Latches device requests as edge- or level-sensitive pending bits and masks them.
- Picks one winner by fixed priority and presents it to the CPU as a one-hot HWInt. Holds it in-service until software writes end-of-interrupt.
- Configured and serviced as a memory-mapped device on the processor bus (PrAddr/PrWD/PrWE side of the bridge).

Parameters:
- N_SRC, 6, number of IRQ sources (1..6); source 0 has highest priority.
- BASE_ADDR, 32'h0000_7F20, word-aligned base of the 5-word register window.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- irq_in  input  N_SRC  device interrupt requests
- dev_addr  input  32  bus address (from PrAddr)
- dev_we  input  1  bus write enable
- dev_be  input  4  byte enables
- dev_wd  input  32  bus write data
- dev_rd  output  32  bus read data, combinational from dev_addr
- int_ack  input  1  one-cycle pulse when the CPU enters the exception handler for an interrupt
- hwint  output  6  one-hot request to the CPU; bits >= N_SRC are tied 0

Behaviour:
- Reset:
  - MASK=0, MODE=0 (all edge), PENDING=0, irq_q=0, state=IDLE, cur_id=0.
  - hwint=0; dev_rd follows the address decode.
- Register map (offset from BASE_ADDR):
  - 0x00 MASK (RW)
  - 0x04 MODE (RW; 1 = level)
  - 0x08 PENDING (R; write-1-to-clear)
  - 0x0C STATUS (R only): [2:0]=cur_id, [8]=ASSERT, [9]=SERVICE
  - 0x10 EOI (W only; data ignored)
- Register fields are N_SRC bits wide and zero-extended on read.
- Reads outside the window, or of unused offsets, return 0.
- A write takes effect only when the address is in the window, dev_we=1 and dev_be=4'b1111. Partial writes are ignored.
- Input stage: irq_q <= irq_in every cycle.
- Edge mode, source i: PENDING[i] sets on the cycle where irq_in[i]=1 and irq_q[i]=0.
- Level mode, source i:
  - PENDING[i] <= irq_in[i] every cycle; a W1C write has no lasting effect.
  - Pending is re-evaluated the next cycle.
- Same-cycle set and W1C clear on a bit: set wins.
- Eligible vector E = PENDING & MASK. Winner = lowest index set in E.
- State machine:
  - IDLE: if E != 0, on the next edge latch cur_id=winner and go to ASSERT. Otherwise stay.
  - ASSERT: hwint = one-hot(cur_id), registered. cur_id is frozen even if a higher-priority source arrives.
    - On int_ack=1: go to SERVICE. hwint drops to 0 on that edge.
    - If PENDING[cur_id] or MASK[cur_id] is cleared by software before ack: return to IDLE and drop hwint.
  - SERVICE: hwint=0, with no nesting.
    - On an EOI write: in edge mode clear PENDING[cur_id]; go to IDLE.
    - A new edge on cur_id in the same cycle as EOI keeps PENDING set.
- Latency (no sync option): a rising edge on irq_in at cycle edge n sets PENDING at edge n. The state enters ASSERT and hwint rises at edge n+1, provided the bit is masked in.
- Back-to-back: after EOI, the next eligible source is asserted one cycle after IDLE is entered.
- int_ack in IDLE or SERVICE is ignored. An EOI write in IDLE or ASSERT is ignored.
- Reset mid-operation: all state clears asynchronously and hwint drops immediately.

Optional Feature:
- Macro IRQ_SYNC_EN.
- When defined: irq_in passes through two flip-flops before irq_q and edge detection, for asynchronous device lines. All irq-to-hwint latencies grow by 2 cycles.
- When undefined: irq_in is used directly as above.
- The register interface is identical in both builds.

Test Plan:
- Write MASK=0x3F and MODE=0. Pulse irq_in[3] high for 1 cycle -> PENDING=0x08 at the next edge, hwint=6'b001000 one cycle later, STATUS=0x103.
- Raise irq_in[4] and irq_in[1] in the same cycle -> hwint=6'b000010.
- Full service of source 1: int_ack -> hwint=0, STATUS=0x201. EOI write -> PENDING=0x10, then hwint=6'b010000 after 1 cycle.
- Set MASK=0x00 and pulse irq_in[2] -> PENDING=0x04 and hwint stays 0. Then write MASK=0x04 -> hwint=6'b000100 one cycle after the write.
- Set MODE=0x01 and hold irq_in[0]=1 -> hwint=6'b000001. After int_ack and EOI with the line still high -> reasserts. Drop the line -> PENDING[0]=0 on the next edge.
- Assert reset while in ASSERT -> hwint=0 before the next clock edge, and all registers read 0. Repeat the edge-mode scenarios with IRQ_SYNC_EN defined -> latency +2 cycles.
